// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON 128/128 key-schedule blocks.
package simon_pkg;

  localparam int SIMON_WORD   = 64;
  localparam int SIMON_ROUNDS = 68;

  // z2 sequence, Z[0] in bit 0. The 62-bit period is extended to 68 bits,
  // so bits 62..67 repeat z2[0..5].
  localparam logic [67:0] SIMON_Z = 68'hD_7369_F885_192C_0EF5;

  // Folds the complement of k_i and the constant 3 into one mask: ~x ^ 3 == x ^ C.
  localparam logic [63:0] SIMON_C = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // z injection for the word that round_idx produces. It is applied only at
  // bit 0. Rounds 1 and 0 produce a don't-care word, so no z is applied there.
  function automatic logic z_bit(input logic [6:0] round_idx, input logic [5:0] bit_idx);
    logic [6:0] zi;
    zi = round_idx - 7'd2;
    return (bit_idx == 6'd0) && (round_idx >= 7'd2) && SIMON_Z[zi];
  endfunction

endpackage

// File: rtl/simon_bit_shiftreg.sv
// Word-wide right-shift/rotate register with serial in/out and parallel load.
// The parallel load takes priority over the shift.
module simon_bit_shiftreg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         rot_i,
  input  logic         sin_i,
  input  logic         pload_i,
  input  logic [W-1:0] pdata_i,
  output logic         sout_o,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         top_bit;

  // In rotate mode the bit leaving at [0] re-enters at the top.
  assign top_bit = rot_i ? q_q[0] : sin_i;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      if (gi == W - 1) begin : g_top
        assign q_d[gi] = pload_i ? pdata_i[gi] : (en_i ? top_bit : q_q[gi]);
      end else begin : g_body
        assign q_d[gi] = pload_i ? pdata_i[gi] : (en_i ? q_q[gi+1] : q_q[gi]);
      end
    end
  endgenerate

  // Register update; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign sout_o = q_q[0];
  assign q_o    = q_q;

endmodule

// File: rtl/simon_key_schedule_inverse.sv
// Bit-serial inverse SIMON 128/128 key schedule. Emits k67 down to k0, LSB first.
// B holds k_{r}, A holds k_{r-1}, and N accumulates k_{r-2} = B ^ S^-3 A ^ S^-4 A ^ C ^ z.
module simon_key_schedule_inverse
  import simon_pkg::*;
#(
  parameter int WORD   = SIMON_WORD,
  parameter int ROUNDS = SIMON_ROUNDS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_in,
  input  logic       load_en,
  input  logic       start,
  input  logic       key_ready,
  output logic       key_out,
  output logic       key_valid,
  output logic [5:0] bit_index,
  output logic [6:0] round_index,
  output logic       key_loaded,
  output logic       busy,
  output logic       done
);

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
  localparam logic [5:0] LAST_BIT   = 6'(WORD - 1);

  state_e          state_q, state_d;
  logic [6:0]      load_cnt_q, load_cnt_d;
  logic            key_loaded_q, key_loaded_d;
  logic [5:0]      bit_index_q, bit_index_d;
  logic [6:0]      round_index_q, round_index_d;

  logic [WORD-1:0] a_q, b_q, n_q;
  logic            a_sout, b_sout, n_sout;
  logic            in_run, in_load, accept, word_end, new_bit;
  logic            a_en, b_en;
  logic [WORD-1:0] a_rot, n_shifted;
  logic            unused_bits;

  assign in_run   = (state_q == RUN);
  assign in_load  = (state_q == IDLE) && load_en && !key_loaded_q;
  assign accept   = in_run && key_ready;
  assign word_end = accept && (bit_index_q == LAST_BIT);

  // A has rotated j times at bit j, so the fixed taps A[3] and A[4] read the
  // original A[j+3] and A[j+4] mod 64.
  assign new_bit   = b_sout ^ a_q[3] ^ a_q[4] ^ SIMON_C[bit_index_q]
                   ^ z_bit(round_index_q, bit_index_q);

  // At the word boundary the 64th rotate/shift is folded into the parallel load.
  assign a_rot     = {a_q[0], a_q[WORD-1:1]};
  assign n_shifted = {new_bit, n_q[WORD-1:1]};

  // Load bits 0..63 fill B (k67), and bits 64..127 fill A (k66).
  assign b_en = accept || (in_load && !load_cnt_q[6]);
  assign a_en = accept || (in_load &&  load_cnt_q[6]);

  simon_bit_shiftreg #(.W(WORD)) u_reg_b (
    .clk     (clk),
    .rst_ni  (reset),
    .en_i    (b_en),
    .rot_i   (1'b0),
    .sin_i   (load_in),
    .pload_i (word_end),
    .pdata_i (a_rot),
    .sout_o  (b_sout),
    .q_o     (b_q)
  );

  simon_bit_shiftreg #(.W(WORD)) u_reg_a (
    .clk     (clk),
    .rst_ni  (reset),
    .en_i    (a_en),
    .rot_i   (in_run),
    .sin_i   (load_in),
    .pload_i (word_end),
    .pdata_i (n_shifted),
    .sout_o  (a_sout),
    .q_o     (a_q)
  );

  simon_bit_shiftreg #(.W(WORD)) u_reg_n (
    .clk     (clk),
    .rst_ni  (reset),
    .en_i    (accept),
    .rot_i   (1'b0),
    .sin_i   (new_bit),
    .pload_i (1'b0),
    .pdata_i ('0),
    .sout_o  (n_sout),
    .q_o     (n_q)
  );

  assign unused_bits = ^{b_q, a_sout, n_sout, n_q[0]};

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      load_cnt_q    <= '0;
      key_loaded_q  <= 1'b0;
      bit_index_q   <= '0;
      round_index_q <= LAST_ROUND;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      key_loaded_q  <= key_loaded_d;
      bit_index_q   <= bit_index_d;
      round_index_q <= round_index_d;
    end
  end

  // Next-state logic for the FSM, load counter and bit/round indices.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    key_loaded_d  = key_loaded_q;
    bit_index_d   = bit_index_q;
    round_index_d = round_index_q;
    unique case (state_q)
      IDLE: begin
        if (in_load) begin
          load_cnt_d = load_cnt_q + 7'd1;
          if (load_cnt_q == 7'd127) key_loaded_d = 1'b1;
        end
        if (start && key_loaded_q) begin
          state_d       = RUN;
          bit_index_d   = '0;
          round_index_d = LAST_ROUND;
        end
      end
      RUN: begin
        if (accept) begin
          bit_index_d = bit_index_q + 6'd1;
          if (word_end) begin
            if (round_index_q == 7'd0) begin
              state_d       = DONE;
              round_index_d = LAST_ROUND;
            end else begin
              round_index_d = round_index_q - 7'd1;
            end
          end
        end
      end
      DONE: begin
        // The key has been consumed; a fresh load is needed before the next start.
        key_loaded_d = 1'b0;
        load_cnt_d   = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_valid   = in_run;
  assign busy        = in_run;
  assign key_out     = in_run & b_sout;
  assign done        = (state_q == DONE);
  assign key_loaded  = key_loaded_q;
  assign bit_index   = bit_index_q;
  assign round_index = round_index_q;

endmodule

// File: tb/tb_simon_key_schedule_inverse.sv
// Scoreboard bench for the inverse SIMON 128/128 key schedule.
module tb_simon_key_schedule_inverse;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_in = 1'b0;
  logic       load_en = 1'b0;
  logic       start = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_out, key_valid, key_loaded, busy, done;
  logic [5:0] bit_index;
  logic [6:0] round_index;

  always #5 clk = ~clk;

  simon_key_schedule_inverse dut (
    .clk         (clk),
    .reset       (reset),
    .load_in     (load_in),
    .load_en     (load_en),
    .start       (start),
    .key_ready   (key_ready),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .bit_index   (bit_index),
    .round_index (round_index),
    .key_loaded  (key_loaded),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int unsigned round;
    logic [63:0] word;
    bit          chk;
  } exp_t;

  localparam logic [127:0] REF_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [63:0]  Z2      = 64'h7369_F885_192C_0EF5;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [63:0] model_k[68];
  logic [63:0] cap[68];

  // Monitor state.
  int unsigned bit_cnt = 0;
  logic [63:0] word_acc = '0;
  bit          prev_hold = 1'b0;
  logic [14:0] prev_snap = '0;
  bit          seen_valid = 1'b0;
  bit          done_seen = 1'b0;
  int          done_cnt = 0;
  int          first_valid_cyc = 0;
  int          done_cyc = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward key expansion of SIMON 128/128 (m=2).
  task automatic expand(input logic [127:0] key);
    logic [63:0] tmp;
    logic [63:0] z2;
    z2 = Z2;
    model_k[0] = key[63:0];
    model_k[1] = key[127:64];
    for (int i = 2; i < 68; i++) begin
      tmp = ror(model_k[i-1], 3);
      tmp = tmp ^ ror(tmp, 1);
      model_k[i] = ~model_k[i-2] ^ tmp ^ {63'd0, z2[6'((i - 2) % 62)]} ^ 64'd3;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      bit_cnt   = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("stall_hold", {key_valid, key_out, round_index, bit_index}, prev_snap);
      prev_hold = key_valid && !key_ready;
      prev_snap = {key_valid, key_out, round_index, bit_index};
      if (key_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (key_valid && key_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bit got round=%0d bit=%0d want no output", round_index, bit_index);
        end else begin
          check("index", {round_index, bit_index}, {7'(sb_q[0].round), 6'(bit_cnt)});
          word_acc[6'(bit_cnt)] = key_out;
          if (bit_cnt == 63) begin
            mon_e = sb_q.pop_front();
            cap[mon_e.round] = word_acc;
            $display("word round=%0d got=%h want=%h checked=%0d", mon_e.round, word_acc, mon_e.word, mon_e.chk);
            if (mon_e.chk) check("word", word_acc, mon_e.word);
            bit_cnt = 0;
          end else begin
            bit_cnt++;
          end
        end
      end
    end
  end

  // v[63:0] = k67, v[127:64] = k66; bits from..to-1 are shifted in.
  task automatic load_bits(input logic [127:0] v, input int from, input int to);
    for (int b = from; b < to; b++) begin
      @(posedge clk); #1;
      load_en = 1'b1;
      load_in = v[7'(b)];
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    load_in = 1'b0;
  endtask

  task automatic push_words(input bit chk);
    exp_t e;
    for (int r = 67; r >= 0; r--) begin
      e.round = r;
      e.word  = model_k[r];
      e.chk   = chk;
      sb_q.push_back(e);
      cap[r] = '0;
    end
  endtask

  task automatic start_and_run(input bit bp, input bit hold, input int budget);
    int n;
    done_seen  = 1'b0;
    done_cnt   = 0;
    seen_valid = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    key_ready = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (n == 0) check("busy_after_start", busy, 1);
      if (done_seen || n >= budget) break;
      start     = hold;
      key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        load_en = 1'b1;
        load_in = 1'($urandom_range(0, 1));
      end
      n++;
    end
    start   = 1'b0;
    load_en = 1'b0;
    load_in = 1'b0;
    if (!done_seen) begin
      n_checks++;
      $display("FAIL run_timeout got no done within %0d cycles want done", budget);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("sb_drained", sb_q.size(), 0);
    if (!bp && done_seen) check("done_latency", done_cyc - first_valid_cyc, 4352);
  endtask

  initial begin
    logic [127:0] v;
    int           n;

    // Reset state.
    expand(REF_KEY);
    v = {model_k[66], model_k[67]};
    @(negedge clk);
    check("rst_key_valid", key_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_done", done, 0);
    check("rst_key_out", key_out, 0);
    check("rst_round_index", round_index, 67);
    check("rst_bit_index", bit_index, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Start gating, followed by the reference run with key_ready held high.
    load_bits(v, 0, 100);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("early_start_busy", busy, 0);
    check("early_key_loaded", key_loaded, 0);
    load_bits(v, 100, 127);
    check("key_loaded_bit127", key_loaded, 0);
    load_bits(v, 127, 128);
    check("key_loaded_bit128", key_loaded, 1);
    push_words(1'b1);
    start_and_run(1'b0, 1'b0, 6000);
    check("ref_k1", cap[1], 64'h0f0e0d0c0b0a0908);
    check("ref_k0", cap[0], 64'h0706050403020100);
    check("key_loaded_after_done", key_loaded, 0);

    // Backpressure: same stream, key_ready toggled pseudo-randomly.
    load_bits(v, 0, 128);
    push_words(1'b1);
    start_and_run(1'b1, 1'b0, 20000);

    // Boundary: k67 = k66 = 0. z2 bit 65 equals z2 bit 3, which is 0, so
    // k65 = C = FFFF_FFFF_FFFF_FFFC.
    load_bits(128'd0, 0, 128);
    for (int r = 0; r < 68; r++) model_k[r] = '0;
    model_k[65] = 64'hFFFF_FFFF_FFFF_FFFC;
    push_words(1'b0);
    sb_q[0].chk = 1'b1;
    sb_q[1].chk = 1'b1;
    sb_q[2].chk = 1'b1;
    start_and_run(1'b0, 1'b0, 6000);
    // The regenerated k1:k0 must expand forward to every emitted word.
    expand({cap[1], cap[0]});
    for (int r = 2; r < 68; r++) check("zero_roundtrip", cap[r], model_k[r]);

    // Mid-run reset at round 40, bit 17.
    expand(REF_KEY);
    load_bits(v, 0, 128);
    push_words(1'b1);
    @(posedge clk); #1;
    start     = 1'b1;
    key_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(round_index == 7'd40 && bit_index == 6'd17) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      n_checks++;
      $display("FAIL midrun_reach got round=%0d bit=%0d want round=40 bit=17", round_index, bit_index);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_key_valid", key_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_key_loaded", key_loaded, 0);
    check("midrst_round_index", round_index, 67);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reload, then hold load_en and start high for the whole run.
    load_bits(v, 0, 128);
    push_words(1'b1);
    start_and_run(1'b0, 1'b1, 6000);
    check("hold_k0", cap[0], 64'h0706050403020100);
    repeat (3) @(posedge clk);
    #1;
    check("hold_idle_busy", busy, 0);
    check("hold_idle_key_loaded", key_loaded, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
